// File: rtl/cnn_pkg.sv
// Shared constants and the output saturation helper for the CNN back-end blocks.
package cnn_pkg;

    localparam int W2        = 27;
    localparam int OW        = 8;
    localparam int SHIFT     = 8;
    localparam int IMG_W_DEF = 24;
    localparam int IMG_H_DEF = 24;

    // Clamp a requantized value into [0, 2^ow-1]; negative values become 0.
    function automatic longint sat_ow(input longint v, input int ow);
        longint max_v;
        max_v = (64'sd1 <<< ow) - 64'sd1;
        if (v < 64'sd0) begin
            return 64'sd0;
        end else if (v > max_v) begin
            return max_v;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One-row buffer of horizontal pooling maxima: single write port, async read, no reset.
module pool_line_buf #(
    parameter int DEPTH = 12,
    parameter int OW    = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [OW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [OW-1:0] rdata
);

    logic [OW-1:0] mem_r [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/bias_relu_pool.sv
// Bias add, ReLU, requantize and 2x2 max-pool of a raster-ordered feature map.
module bias_relu_pool
    import cnn_pkg::*;
#(
    parameter int W2    = cnn_pkg::W2,
    parameter int IMG_W = cnn_pkg::IMG_W_DEF,
    parameter int IMG_H = cnn_pkg::IMG_H_DEF,
    parameter int SHIFT = cnn_pkg::SHIFT,
    parameter int OW    = cnn_pkg::OW,
    parameter int AW    = ((IMG_W * IMG_H / 4) > 1) ? $clog2(IMG_W * IMG_H / 4) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_start,
    input  logic signed [W2-1:0] bias,
    input  logic                 in_valid,
    input  logic signed [W2-1:0] in_sum,
    output logic                 out_valid,
    output logic [OW-1:0]        out_data,
    output logic [AW-1:0]        out_addr,
    output logic                 frame_done
);

    localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LBD  = IMG_W / 2;
    localparam int LBAW = (LBD > 1) ? $clog2(LBD) : 1;

    if (((IMG_W % 2) != 0) || ((IMG_H % 2) != 0)) begin : g_bad_dims
        $error("bias_relu_pool: IMG_W and IMG_H must be even");
    end

    logic signed [W2-1:0] bias_r;
    logic signed [W2-1:0] bias_eff_s;
    logic signed [W2:0]   sum_s;
    logic signed [W2:0]   shifted_s;
    logic [OW-1:0]        q_next_s;
    logic [OW-1:0]        q_r;
    logic                 s1_valid_r;
    logic [CW-1:0]        col_r;
    logic [RW-1:0]        row_r;
    logic [OW-1:0]        hold_r;
    logic                 pool_en_s;
    logic                 lb_we_s;
    logic [LBAW-1:0]      lb_addr_s;
    logic [OW-1:0]        lb_rdata_s;
    logic [OW-1:0]        pair_max_s;
    logic [OW-1:0]        quad_max_s;
    logic [AW-1:0]        addr_s;
    logic                 last_s;

    // Stage-1 arithmetic; a frame_start sample already uses the incoming bias.
    always_comb begin
        bias_eff_s = bias_r;
        if (frame_start) begin
            bias_eff_s = bias;
        end else begin
            bias_eff_s = bias_r;
        end
        sum_s     = $signed({bias_eff_s[W2-1], bias_eff_s}) + $signed({in_sum[W2-1], in_sum});
        shifted_s = sum_s >>> SHIFT;
        q_next_s  = OW'(sat_ow(longint'(shifted_s), OW));
    end

    // Stage-1 register and bias latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_r     <= '0;
            q_r        <= '0;
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= in_valid;
            if (frame_start) begin
                bias_r <= bias;
            end
            if (in_valid) begin
                q_r <= q_next_s;
            end
        end
    end

    // A stage-1 pixel left over from an abandoned frame is dropped on frame_start.
    always_comb begin
        pool_en_s  = s1_valid_r && !frame_start;
        lb_we_s    = pool_en_s && !row_r[0] && col_r[0];
        lb_addr_s  = LBAW'(col_r >> 1);
        pair_max_s = (hold_r > q_r) ? hold_r : q_r;
        quad_max_s = (lb_rdata_s > pair_max_s) ? lb_rdata_s : pair_max_s;
        addr_s     = AW'(((32'(row_r) >> 1) * 32'(IMG_W / 2)) + (32'(col_r) >> 1));
        last_s     = (col_r == CW'(IMG_W - 1)) && (row_r == RW'(IMG_H - 1));
    end

    // Raster position of the stage-1 pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r <= '0;
            row_r <= '0;
        end else if (frame_start) begin
            col_r <= '0;
            row_r <= '0;
        end else if (s1_valid_r) begin
            if (col_r == CW'(IMG_W - 1)) begin
                col_r <= '0;
                row_r <= (row_r == RW'(IMG_H - 1)) ? '0 : row_r + RW'(1);
            end else begin
                col_r <= col_r + CW'(1);
            end
        end
    end

    // Horizontal pair hold and pooled output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_r     <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_addr   <= '0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (pool_en_s && !col_r[0]) begin
                hold_r <= q_r;
            end
            if (pool_en_s && row_r[0] && col_r[0]) begin
                out_valid  <= 1'b1;
                out_data   <= quad_max_s;
                out_addr   <= addr_s;
                frame_done <= last_s;
            end
        end
    end

    pool_line_buf #(
        .DEPTH (LBD),
        .OW    (OW),
        .AW    (LBAW)
    ) u_line_buf (
        .clk   (clk),
        .we    (lb_we_s),
        .waddr (lb_addr_s),
        .wdata (pair_max_s),
        .raddr (lb_addr_s),
        .rdata (lb_rdata_s)
    );

endmodule

// File: tb/tb_bias_relu_pool.sv
// Scoreboard bench for bias_relu_pool on a 4x4 map with SHIFT = 8.
module tb_bias_relu_pool;

    localparam int W2    = 27;
    localparam int IMG_W = 4;
    localparam int IMG_H = 4;
    localparam int SHIFT = 8;
    localparam int OW    = 8;
    localparam int AW    = 2;

    typedef struct {
        int data;
        int addr;
        int done;
        int cyc;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 frame_start = 1'b0;
    logic signed [W2-1:0] bias = '0;
    logic                 in_valid = 1'b0;
    logic signed [W2-1:0] in_sum = '0;
    logic                 out_valid;
    logic [OW-1:0]        out_data;
    logic [AW-1:0]        out_addr;
    logic                 frame_done;

    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;
    exp_t sb[$];

    // Reference model state.
    int   m_col = 0;
    int   m_row = 0;
    int   m_bias = 0;
    int   grid [IMG_H][IMG_W];
    bit   pend_v = 1'b0;
    exp_t pend;

    bias_relu_pool #(
        .W2(W2), .IMG_W(IMG_W), .IMG_H(IMG_H), .SHIFT(SHIFT), .OW(OW), .AW(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .bias(bias),
        .in_valid(in_valid), .in_sum(in_sum), .out_valid(out_valid),
        .out_data(out_data), .out_addr(out_addr), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int ref_q(input longint s, input longint b);
        longint v;
        v = s + b;
        if (v < 0) return 0;
        v = v / 256;
        if (v > 255) return 255;
        return int'(v);
    endfunction

    // One input cycle; a completion is committed to the scoreboard only if the
    // following cycle does not carry frame_start (which would flush it).
    task automatic drive(input bit fs, input bit v, input longint s, input longint b);
        int qv;
        int mx;
        @(posedge clk);
        #1;
        if (pend_v && !fs) sb.push_back(pend);
        pend_v      = 1'b0;
        frame_start = fs;
        in_valid    = v;
        in_sum      = W2'(s);
        bias        = W2'(b);
        if (fs) begin
            m_col  = 0;
            m_row  = 0;
            m_bias = int'(b);
        end
        if (v) begin
            qv = ref_q(s, m_bias);
            grid[m_row][m_col] = qv;
            if ((m_row % 2 == 1) && (m_col % 2 == 1)) begin
                mx = grid[m_row-1][m_col-1];
                if (grid[m_row-1][m_col] > mx) mx = grid[m_row-1][m_col];
                if (grid[m_row][m_col-1] > mx) mx = grid[m_row][m_col-1];
                if (qv > mx) mx = qv;
                pend.data = mx;
                pend.addr = (m_row / 2) * (IMG_W / 2) + (m_col / 2);
                pend.done = (pend.addr == IMG_W * IMG_H / 4 - 1) ? 1 : 0;
                pend.cyc  = cyc + 2;
                pend_v    = 1'b1;
            end
            m_col++;
            if (m_col == IMG_W) begin
                m_col = 0;
                m_row = (m_row + 1) % IMG_H;
            end
        end
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        frame_start = 1'b0;
        in_valid    = 1'b0;
        pend_v      = 1'b0;
        m_col       = 0;
        m_row       = 0;
        m_bias      = 0;
        #2;
        check_eq({tag, "_rst_valid"}, out_valid, 0);
        check_eq({tag, "_rst_data"}, out_data, 0);
        check_eq({tag, "_rst_addr"}, out_addr, 0);
        check_eq({tag, "_rst_done"}, frame_done, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // kind 0: ramp 256*k; kind 1: constant cval. gaps inserts idle cycles.
    task automatic run_frame(input bit fs_first, input longint b, input int kind,
                             input longint cval, input bit gaps, input int n);
        longint s;
        for (int k = 0; k < n; k++) begin
            s = (kind == 0) ? longint'(256 * k) : cval;
            if (gaps && (k > 0)) drive(1'b0, 1'b0, 0, b);
            drive(fs_first && (k == 0), 1'b1, s, b);
        end
    endtask

    task automatic drain(input string tag);
        drive(1'b0, 1'b0, 0, m_bias);
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        check_eq({tag, "_drain"}, sb.size(), 0);
        sb.delete();
    endtask

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && frame_done && !out_valid) check_eq("done_without_valid", out_valid, 1);
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_output", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check_eq("out_data", out_data, e.data);
                check_eq("out_addr", out_addr, e.addr);
                check_eq("frame_done", frame_done, e.done);
                check_eq("latency_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset("init");
        // Scenario 1: ramp.
        run_frame(1'b1, 0, 0, 0, 1'b0, 16);
        drain("s1");
        // Scenario 2: negative sums.
        run_frame(1'b1, 0, 1, -1000, 1'b0, 16);
        drain("s2");
        // Scenario 3: saturation.
        run_frame(1'b1, 0, 1, 64'sd67108863, 1'b0, 16);
        drain("s3");
        // Scenario 4: negative bias latched on frame_start.
        run_frame(1'b1, -512, 1, 768, 1'b0, 16);
        drain("s4");
        // Scenario 5: ramp with alternate idle cycles.
        run_frame(1'b1, 0, 0, 0, 1'b1, 16);
        drain("s5");
        // Scenario 6a: restart after 6 inputs, then a full frame.
        run_frame(1'b1, 0, 0, 0, 1'b0, 6);
        run_frame(1'b1, 0, 0, 0, 1'b0, 16);
        drain("s6a");
        // Scenario 6b: reset after 6 inputs, then a full frame without frame_start.
        run_frame(1'b1, 0, 0, 0, 1'b0, 6);
        do_reset("s6b");
        run_frame(1'b0, 0, 0, 0, 1'b0, 16);
        drain("s6b");
        // Back-to-back frames relying on counter wrap.
        run_frame(1'b1, 0, 0, 0, 1'b0, 16);
        run_frame(1'b0, 0, 1, 768, 1'b0, 16);
        drain("wrap");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/bias_relu_pool.md
BIAS_RELU_POOL -- requirements
Module: bias_relu_pool

Interface
REQ-001 Parameters SHALL be:
- W2 = 27: input sum width
- IMG_W = 24: feature-map width
- IMG_H = 24: feature-map height
- SHIFT = 8: requantize right-shift
- OW = 8: output pixel width
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; ports SHALL be named clk and rst_n.
REQ-003 Ports SHALL be:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- frame_start  in  1  restart frame; latch bias
- bias  in  W2 signed  per-map bias, sampled on frame_start
- in_valid  in  1  in_sum valid this cycle
- in_sum  in  W2 signed  16-channel sum from the upstream adder tree, raster order
- out_valid  out  1  one-cycle pooled-pixel strobe
- out_data  out  OW unsigned  pooled pixel
- out_addr  out  clog2(IMG_W*IMG_H/4)  pooled raster index
- frame_done  out  1  pulses with the last pooled pixel of a frame

Function
REQ-004 Stage 1 SHALL register q = sat_OW(max(0, in_sum + bias_reg) >>> SHIFT) using a W2+1-bit signed add; sat clamps to 2^OW-1; negative sums give 0.
REQ-005 Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) SHALL advance on each stage-1 valid, col first; at (IMG_W-1, IMG_H-1) both SHALL wrap to 0 without frame_start.
REQ-006 Even row, even col: hold <= q.
REQ-007 Even row, odd col: line_buf[col>>1] <= max(hold, q).
REQ-008 Odd row, even col: hold <= q.
REQ-009 Odd row, odd col: out_data <= max(line_buf[col>>1], hold, q), with out_valid = 1 for one cycle.
REQ-010 out_addr SHALL equal (row>>1)*(IMG_W/2) + (col>>1) of the completing pixel; frame_done SHALL assert with out_valid for out_addr = IMG_W*IMG_H/4 - 1.
REQ-011 Latency from the in_valid cycle of the completing (odd row, odd col) sample to out_valid SHALL be exactly 2 cycles; throughput SHALL be one input per cycle with no backpressure.
REQ-012 in_valid low SHALL freeze counters, hold and line_buf; gaps of any length SHALL NOT alter results.
REQ-013 frame_start SHALL load bias_reg, zero col and row, and flush the stage-1 valid; a simultaneous in_valid sample SHALL be processed as pixel (0,0) using the new bias.
REQ-014 frame_start mid-frame SHALL abandon the partial frame; no out_valid from the abandoned frame SHALL appear after the restart cycle + 1.
REQ-015 IMG_W and IMG_H SHALL be even; elaboration SHALL fail otherwise.

Reset
REQ-016 With rst_n low, the following SHALL be 0: out_valid, out_data, out_addr, frame_done, col, row, hold, bias_reg, stage-1 valid. line_buf contents are don't-care.
REQ-017 Reset assertion mid-frame SHALL take effect immediately; the first valid after release SHALL be pixel (0,0).

Structure
REQ-018 A shared package cnn_pkg SHALL hold W2, OW, SHIFT, the IMG_W/IMG_H defaults and the saturate-to-OW function.
REQ-019 The line buffer SHALL be a sub-module pool_line_buf: IMG_W/2 x OW, one write port and one async-read port, no reset.

Verification
REQ-020 The bench SHALL use IMG_W = IMG_H = 4, SHIFT = 8, bias = 0 and cover these scenarios:
- Scenario 1: inputs 256*k for k = 0..15 raster -> out_data 5, 7, 13, 15 at out_addr 0..3; frame_done with addr 3.
- Scenario 2: all in_sum = -1000 -> four outputs of 0.
- Scenario 3: in_sum = 2^26-1 everywhere -> four outputs of 255 (saturation).
- Scenario 4: bias = -512 on frame_start, in_sum = 768 everywhere -> all outputs 1.
- Scenario 5: Scenario 1 with in_valid low on alternate cycles -> same outputs; each out_valid exactly 2 cycles after its completing input.
- Scenario 6: frame_start after 6 inputs, then a full frame of Scenario 1 data -> exactly 4 outputs matching Scenario 1. Separately, rst_n pulsed mid-frame then a full frame -> same.
